seq_slice_comparator: RTL

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per clock, most-significant slice first, and reports equal / less-than / greater-than. It extends the team's combinational 3-bit equality comparator to arbitrary width, adds magnitude and signed compare, and adds valid/ready handshakes. It sits between operand registers and control logic in the datapath.

---
 rtl/seq_slice_comparator.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_slice_comparator.sv
// Multi-cycle slice-serial magnitude comparator (unsigned or two's complement).
// Define SLICE_CMP_EARLY_EXIT_EN to finish on the first unequal slice.
module seq_slice_comparator #(
   parameter int WIDTH  = 12,
   parameter int DIGIT  = 3,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   localparam int NSLICE = WIDTH / DIGIT;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa, sb;
   logic [CW-1:0]    cnt;
   logic             fd, flt, fgt;

   logic [DIGIT-1:0] sl_a, sl_b;
   logic             new_fd, new_lt, new_gt, last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      sl_a = sa[WIDTH-1 -: DIGIT];
      sl_b = sb[WIDTH-1 -: DIGIT];
      // flipping the sign bit maps two's complement onto unsigned order
      if (SIGNED != 0 && cnt == CNT_TOP) begin
         sl_a[DIGIT-1] = ~sl_a[DIGIT-1];
         sl_b[DIGIT-1] = ~sl_b[DIGIT-1];
      end
      new_fd = fd | (sl_a != sl_b);
      new_lt = fd ? flt : (sl_a < sl_b);
      new_gt = fd ? fgt : (sl_a > sl_b);
`ifdef SLICE_CMP_EARLY_EXIT_EN
      last = (cnt == '0) || new_fd;
`else
      last = (cnt == '0);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         cnt   <= '0;
         fd    <= 1'b0;
         flt   <= 1'b0;
         fgt   <= 1'b0;
         eq    <= 1'b0;
         lt    <= 1'b0;
         gt    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sa    <= a;
                  sb    <= b;
                  cnt   <= CNT_TOP;
                  fd    <= 1'b0;
                  flt   <= 1'b0;
                  fgt   <= 1'b0;
                  state <= CMP;
               end
            end
            CMP: begin
               sa  <= sa << DIGIT;
               sb  <= sb << DIGIT;
               cnt <= cnt - CW'(1);
               fd  <= new_fd;
               flt <= new_lt;
               fgt <= new_gt;
               if (last) begin
                  eq    <= ~new_fd;
                  lt    <= new_lt;
                  gt    <= new_gt;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
